// File: rtl/sim_monitor_pkg.sv
// sim_monitor_pkg: FSM state encodings and output record kinds shared by sim_monitor.
// Rev 1.0 - initial release.
`default_nettype none

package sim_monitor_pkg;

    typedef enum logic [2:0] {
        MON_RUN       = 3'd0,
        MON_DRAIN     = 3'd1,
        MON_DUMP_REQ  = 3'd2,
        MON_DUMP_WAIT = 3'd3,
        MON_DUMP_OUT  = 3'd4,
        MON_DONE      = 3'd5
    } mon_state_t;

    localparam logic MON_KIND_CHAR = 1'b0;
    localparam logic MON_KIND_WORD = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sim_monitor_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with full/empty flags; push on full is accepted only with a pop.
// Rev 1.0 - initial release.
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full    = w_full;
    assign o_empty   = w_empty;

endmodule

`default_nettype wire

// File: rtl/sim_monitor.sv
// sim_monitor: console capture FIFO, cycle watchdog and post-run data-memory dump over one valid/ready port.
// Optional watchdog: define SIM_MONITOR_TIMEOUT_EN.  Rev 1.0 - initial release.
`default_nettype none

module sim_monitor
    import sim_monitor_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int PRINT_DEPTH    = 16,
    parameter int DUMP_BASE      = 0,
    parameter int DUMP_COUNT     = 10,
    parameter int TIMEOUT_CYCLES = 100,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             print_flag,
    input  logic [7:0]       print_char,
    input  logic             halt,
    output logic             dm_rd_en,
    output logic [XLEN-1:0]  dm_addr,
    input  logic [XLEN-1:0]  dm_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_kind,
    output logic [XLEN-1:0]  out_data,
    output logic [7:0]       out_index,
    output logic             done,
    output logic             timed_out,
    output logic             dropped,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [7:0] c_LAST_IDX = 8'((DUMP_COUNT > 0) ? DUMP_COUNT - 1 : 0);

    mon_state_t       r_state;
    logic [7:0]       r_idx;
    logic [XLEN-1:0]  r_hold;
    logic             r_armed;
    logic             r_prev_flag;
    logic             r_dropped;
    logic [CNT_W-1:0] r_cycle;

    logic             w_evt;
    logic             w_push;
    logic             w_pop;
    logic             w_char_valid;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [7:0]       w_head;
    logic             w_dump_out;
    logic [XLEN-1:0]  w_addr;

    assign w_evt        = r_armed && (print_flag != r_prev_flag) && (r_state == MON_RUN);
    assign w_char_valid = ((r_state == MON_RUN) || (r_state == MON_DRAIN)) && !w_fifo_empty;
    assign w_pop        = w_char_valid && out_ready;
    assign w_push       = w_evt && (!w_fifo_full || w_pop);
    assign w_dump_out   = (r_state == MON_DUMP_OUT);
    assign w_addr       = XLEN'(DUMP_BASE) + XLEN'({r_idx, 2'b00});

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (PRINT_DEPTH)
    ) u_print_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_wr_data (print_char),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    // The first clock after reset only samples the flag level, so a stale level never prints.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed     <= 1'b0;
            r_prev_flag <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_armed     <= 1'b1;
            r_prev_flag <= print_flag;
            if (w_evt && w_fifo_full && !w_pop) r_dropped <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle <= '0;
        end else if ((r_state != MON_DONE) && (r_cycle != {CNT_W{1'b1}})) begin
            r_cycle <= r_cycle + 1'b1;
        end
    end

`ifdef SIM_MONITOR_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic r_timed_out;
    logic w_wd_hit;
    assign w_wd_hit  = (r_cycle == c_WD_LAST);
    assign timed_out = r_timed_out;
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= MON_RUN;
            r_idx       <= 8'd0;
            r_hold      <= '0;
`ifdef SIM_MONITOR_TIMEOUT_EN
            r_timed_out <= 1'b0;
`endif
        end else begin
            case (r_state)
                MON_RUN: begin
                    // halt takes priority over a watchdog hit in the same cycle
                    if (halt) begin
                        r_state <= MON_DRAIN;
`ifdef SIM_MONITOR_TIMEOUT_EN
                    end else if (w_wd_hit) begin
                        r_timed_out <= 1'b1;
                        r_state     <= MON_DRAIN;
`endif
                    end
                end
                MON_DRAIN: begin
                    if (w_fifo_empty) begin
                        r_state <= (DUMP_COUNT == 0) ? MON_DONE : MON_DUMP_REQ;
                    end
                end
                MON_DUMP_REQ: begin
                    r_state <= MON_DUMP_WAIT;
                end
                MON_DUMP_WAIT: begin
                    r_hold  <= dm_rdata;
                    r_state <= MON_DUMP_OUT;
                end
                MON_DUMP_OUT: begin
                    if (out_ready) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= MON_DONE;
                        end else begin
                            r_idx   <= r_idx + 8'd1;
                            r_state <= MON_DUMP_REQ;
                        end
                    end
                end
                MON_DONE: begin
                    r_state <= MON_DONE;
                end
                default: begin
                    r_state <= MON_RUN;
                end
            endcase
        end
    end

    assign dm_rd_en    = (r_state == MON_DUMP_REQ);
    assign dm_addr     = dm_rd_en ? w_addr : '0;
    assign out_valid   = w_char_valid || w_dump_out;
    assign out_kind    = w_dump_out ? MON_KIND_WORD : MON_KIND_CHAR;
    assign out_data    = w_dump_out   ? r_hold :
                         w_char_valid ? {{(XLEN-8){1'b0}}, w_head} : '0;
    assign out_index   = w_dump_out ? r_idx : 8'd0;
    assign done        = (r_state == MON_DONE);
    assign dropped     = r_dropped;
    assign cycle_count = r_cycle;

endmodule

`default_nettype wire

// File: doc/sim_monitor.md
# sim_monitor

Synthesizable run-control and observation block that sits beside `Top` in the pipeline-CPU simulation environment. It replaces ad-hoc bench logic for console characters, halt waiting, a fixed cycle budget and post-run memory dumps. The block:
- captures console characters on each `print_flag` toggle into a FIFO;
- bounds the run with a cycle watchdog;
- on halt or timeout, drains pending characters and then streams a parametrised window of data-memory words out through one valid/ready port.

## Interface
Parameters:
- `XLEN`, 32, data/address width.
- `PRINT_DEPTH`, 16, print FIFO entries; must be a power of 2, ≥2.
- `DUMP_BASE`, 0, byte address of the first dumped word; must be 4-aligned.
- `DUMP_COUNT`, 10, number of words dumped, 0..255.
- `TIMEOUT_CYCLES`, 100, watchdog limit in clocks; must be ≥1.
- `CNT_W`, 32, width of the cycle counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `print_flag` in 1: each level change is one print event.
- `print_char` in 8: character, sampled together with the event (x11[7:0]).
- `halt` in 1: program finished, level.
- `dm_rd_en` out 1: data-memory read strobe.
- `dm_addr` out XLEN: byte address of the read.
- `dm_rdata` in XLEN: read data, valid the cycle after `dm_rd_en`.
- `out_valid` out 1: output record valid.
- `out_ready` in 1: consumer accepts the record.
- `out_kind` out 1: record type; 0 = char, 1 = dump word.
- `out_data` out XLEN: payload; a char record is zero-extended.
- `out_index` out 8: dump word index; 0 for char records.
- `done` out 1: dump complete, sticky.
- `timed_out` out 1: watchdog fired, sticky.
- `dropped` out 1: a print event was lost because the FIFO was full, sticky.
- `cycle_count` out CNT_W: clocks since reset.

## Operation
- **Reset values:** every output is 0 and the FSM is in RUN.
  - Internal `armed` = 0. During the first clock after reset release, `prev_flag` loads `print_flag` with no event raised; `armed` is set at that edge.
- **Print capture:** an event occurs when `armed` and `print_flag != prev_flag`. It pushes `print_char`.
  - If the FIFO is full, the character is discarded and `dropped` is set.
  - Capture is enabled only in RUN.
- **FSM states:** RUN, DRAIN, DUMP_REQ, DUMP_WAIT, DUMP_OUT, DONE.
  - **RUN:** the FIFO head is presented as a char record. `halt` moves to DRAIN. A watchdog hit sets `timed_out` and moves to DRAIN.
  - **DRAIN:** FIFO output continues. When the FIFO is empty, go to DUMP_REQ, or to DONE if `DUMP_COUNT`==0.
  - **DUMP_REQ:** `dm_rd_en`=1 and `dm_addr`=`DUMP_BASE`+4·idx. Go to DUMP_WAIT.
  - **DUMP_WAIT:** latch `dm_rdata` into the hold register. Go to DUMP_OUT.
  - **DUMP_OUT:** `out_valid`=1, `out_kind`=1, `out_index`=idx. On `out_ready`, idx increments. Go to DUMP_REQ, or to DONE after idx = `DUMP_COUNT`-1.
  - **DONE:** `done`=1 and `out_valid`=0. This state is terminal until reset.
- **Handshake:** once `out_valid` is asserted, it and the payload stay stable until `out_ready`. A record transfers on a cycle where both are high.
- **Address arithmetic:** addresses are computed modulo 2^XLEN, so they wrap silently.
- **`cycle_count`:** increments every clock in every state except DONE and saturates at all-ones.
- **Watchdog hit:** `cycle_count` == `TIMEOUT_CYCLES`-1 while in RUN.
  - If `halt` is high in the same cycle, halt wins and `timed_out` stays 0.
- **Push during pop:** a push and a pop in the same cycle on a full FIFO both succeed; nothing is dropped.
- **Reset mid-dump:** the dump is abandoned, all state clears, and the block returns to RUN (unarmed).

## Timing
- **Event to output:** an event detected at edge n appears as `out_valid` from cycle n+1 if the FIFO was empty. The FIFO is show-ahead.
- **Char throughput:** one char per clock with `out_ready` held high.
- **Dump latency:** 3 clocks per word (REQ, WAIT, OUT) with `out_ready` high. The first `dm_rd_en` comes one clock after DRAIN sees the FIFO empty.
- **Halt response:** `halt` sampled high at edge n puts the FSM in DRAIN from n+1. An event at edge n is still captured.
- **End of dump:** `done` rises the clock after the last dump word transfers.

## Configuration
- `SIM_MONITOR_TIMEOUT_EN` defined: the watchdog is active as described above.
- Not defined: no watchdog comparator is built and `timed_out` is tied to 0. Only `halt` ends RUN; `cycle_count` still counts.

## Structure
- Add to the shared `define.v`:
  - FSM state encodings: `MON_RUN`, `MON_DRAIN`, `MON_DUMP_REQ`, `MON_DUMP_WAIT`, `MON_DUMP_OUT`, `MON_DONE`.
  - Record kinds: `MON_KIND_CHAR`=0, `MON_KIND_WORD`=1.
- Sub-module `sync_fifo`, parametrised by width and depth, with full/empty flags and show-ahead read. It is instantiated with width 8 and depth `PRINT_DEPTH`.

## Test plan
- **Console:** `print_flag` toggled 3 times with 'H','i','\n', `out_ready`=1 → three char records, `out_data` 0x48, 0x69, 0x0A in order, each one clock after its event.
- **Overflow:** `PRINT_DEPTH`=4, `out_ready`=0, 6 events → 4 chars retained, `dropped`=1. Raising `out_ready` yields exactly the first 4 chars.
- **Halt and dump:** `halt` at cycle 20, `DUMP_BASE`=0, `DUMP_COUNT`=10, memory word i = i·i → `dm_addr` 0,4,…,36 and records idx 0..9 with data 0,1,4,…,81. `done` rises; `timed_out`=0.
- **Watchdog:** with `SIM_MONITOR_TIMEOUT_EN` set, `TIMEOUT_CYCLES`=100, `halt` never asserted → `timed_out`=1 at cycle 99, then the dump runs.
  - Same run with the macro undefined → the FSM stays in RUN and `timed_out`=0.
- **Simultaneous halt/timeout:** `halt` rises on cycle 99 → `timed_out`=0.
- **Backpressure/reset:** `out_ready` toggles randomly during the dump → the payload stays stable while stalled.
  - `rst` asserted mid-dump → all outputs 0 and the block returns to RUN; the first `print_flag` level after release raises no event.
